// File: rtl/uart_frame_parser_if.sv
// rtl/uart_frame_parser_if.sv - byte stream, held-frame readout and error signals of the frame parser
interface uart_frame_parser_if;
   logic [7:0] rx_data;
   logic       rx_done;
   logic [7:0] rd_addr;
   logic       frm_ack;
   logic       frm_valid;
   logic [7:0] frm_cmd;
   logic [7:0] frm_len;
   logic [7:0] rd_data;
   logic       frm_err;
   logic [2:0] err_code;

   // master: byte source and application side; slave: the parser
   modport master (
      output rx_data, rx_done, rd_addr, frm_ack,
      input  frm_valid, frm_cmd, frm_len, rd_data, frm_err, err_code
   );

   modport slave (
      input  rx_data, rx_done, rd_addr, frm_ack,
      output frm_valid, frm_cmd, frm_len, rd_data, frm_err, err_code
   );
endinterface

// File: rtl/uart_frame_parser.sv
// rtl/uart_frame_parser.sv - HEADER/CMD/LEN/PAYLOAD/CHK frame parser behind the UART receiver
// Define FRAME_TIMEOUT_EN to abandon partial frames after TIMEOUT_CYCLES idle clocks.
module uart_frame_parser #(
   parameter logic [7:0] HEADER         = 8'hA5,
   parameter int         MAX_LEN        = 16,
   parameter int         TIMEOUT_CYCLES = 1000000
) (
   input logic                clk,
   input logic                rst_n,
   uart_frame_parser_if.slave bus
);

   localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
   localparam logic [2:0] ERR_CHK   = 3'd1;
   localparam logic [2:0] ERR_LEN   = 3'd2;
   localparam logic [2:0] ERR_OVR   = 3'd3;
   localparam logic [2:0] ERR_TMO   = 3'd4;

   if (MAX_LEN < 1 || MAX_LEN > 255 || TIMEOUT_CYCLES < 2) begin : g_param_check
      $error("uart_frame_parser: MAX_LEN must be 1..255 and TIMEOUT_CYCLES at least 2");
   end

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_CMD     = 3'd1,
      S_LEN     = 3'd2,
      S_PAYLOAD = 3'd3,
      S_CHK     = 3'd4,
      S_HOLD    = 3'd5
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] cmd_q, cmd_d;
   logic [7:0] len_q, len_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] chk_q, chk_d;
   logic [7:0] cap_q  [MAX_LEN];
   logic [7:0] cap_d  [MAX_LEN];
   logic [7:0] held_q [MAX_LEN];
   logic [7:0] held_d [MAX_LEN];
   logic [7:0] frm_cmd_q, frm_cmd_d;
   logic [7:0] frm_len_q, frm_len_d;
   logic       frm_err_q, frm_err_d;
   logic [2:0] err_code_q, err_code_d;
   logic       frm_valid;
   logic [7:0] rd_data;
   logic       tmo_hit;

   logic       rx_done;
   logic [7:0] rx_data;
   logic       frm_ack;
   logic       is_header;
   logic       last_payload;

   assign rx_done      = bus.rx_done;
   assign rx_data      = bus.rx_data;
   assign frm_ack      = bus.frm_ack;
   assign is_header    = (rx_data == HEADER);
   assign last_payload = (cnt_q == len_q - 8'd1);

`ifdef FRAME_TIMEOUT_EN
   localparam int            TW       = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
   logic          in_frame;

   // Counter restarts on every byte and whenever no frame is being assembled.
   always_comb begin
      in_frame  = (state_q == S_CMD) || (state_q == S_LEN) ||
                  (state_q == S_PAYLOAD) || (state_q == S_CHK);
      tmo_hit   = in_frame && !rx_done && (tmo_cnt_q == TMO_LAST);
      tmo_cnt_d = tmo_cnt_q + 1'b1;
      if (!in_frame || rx_done || tmo_hit) begin
         tmo_cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt_q <= '0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
      end
   end
`else
   assign tmo_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (tmo_hit) begin
         state_d = S_IDLE;
      end else if (rx_done) begin
         case (state_q)
            S_IDLE:    if (is_header) state_d = S_CMD;
            S_CMD:     state_d = S_LEN;
            S_LEN: begin
               if (rx_data > MAX_LEN_B) state_d = S_IDLE;
               else if (rx_data == 8'd0) state_d = S_CHK;
               else state_d = S_PAYLOAD;
            end
            S_PAYLOAD: if (last_payload) state_d = S_CHK;
            S_CHK:     state_d = (rx_data == chk_q) ? S_HOLD : S_IDLE;
            // An ack alongside a byte frees the parser and the byte is treated as an IDLE byte.
            S_HOLD:    if (frm_ack) state_d = is_header ? S_CMD : S_IDLE;
            default:   state_d = S_IDLE;
         endcase
      end else if (state_q == S_HOLD && frm_ack) begin
         state_d = S_IDLE;
      end
   end

   always_comb begin
      cmd_d      = cmd_q;
      len_d      = len_q;
      cnt_d      = cnt_q;
      chk_d      = chk_q;
      cap_d      = cap_q;
      held_d     = held_q;
      frm_cmd_d  = frm_cmd_q;
      frm_len_d  = frm_len_q;
      frm_err_d  = 1'b0;
      err_code_d = err_code_q;
      frm_valid  = (state_q == S_HOLD);

      if (tmo_hit) begin
         frm_err_d  = 1'b1;
         err_code_d = ERR_TMO;
      end else if (rx_done) begin
         case (state_q)
            S_IDLE: if (is_header) chk_d = 8'h00;
            S_CMD: begin
               cmd_d = rx_data;
               chk_d = chk_q ^ rx_data;
            end
            S_LEN: begin
               if (rx_data > MAX_LEN_B) begin
                  frm_err_d  = 1'b1;
                  err_code_d = ERR_LEN;
               end else begin
                  len_d = rx_data;
                  chk_d = chk_q ^ rx_data;
                  cnt_d = 8'd0;
               end
            end
            S_PAYLOAD: begin
               for (int i = 0; i < MAX_LEN; i++) begin
                  if (cnt_q == 8'(i)) cap_d[i] = rx_data;
               end
               chk_d = chk_q ^ rx_data;
               // Holding on the last byte keeps the counter within 0..MAX_LEN-1.
               if (!last_payload) cnt_d = cnt_q + 8'd1;
            end
            S_CHK: begin
               if (rx_data == chk_q) begin
                  frm_cmd_d = cmd_q;
                  frm_len_d = len_q;
                  held_d    = cap_q;
               end else begin
                  frm_err_d  = 1'b1;
                  err_code_d = ERR_CHK;
               end
            end
            S_HOLD: begin
               if (frm_ack) begin
                  if (is_header) chk_d = 8'h00;
               end else begin
                  frm_err_d  = 1'b1;
                  err_code_d = ERR_OVR;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_q      <= 8'h00;
         len_q      <= 8'h00;
         cnt_q      <= 8'h00;
         chk_q      <= 8'h00;
         frm_cmd_q  <= 8'h00;
         frm_len_q  <= 8'h00;
         frm_err_q  <= 1'b0;
         err_code_q <= 3'd0;
         for (int i = 0; i < MAX_LEN; i++) begin
            cap_q[i]  <= 8'h00;
            held_q[i] <= 8'h00;
         end
      end else begin
         cmd_q      <= cmd_d;
         len_q      <= len_d;
         cnt_q      <= cnt_d;
         chk_q      <= chk_d;
         frm_cmd_q  <= frm_cmd_d;
         frm_len_q  <= frm_len_d;
         frm_err_q  <= frm_err_d;
         err_code_q <= err_code_d;
         cap_q      <= cap_d;
         held_q     <= held_d;
      end
   end

   always_comb begin
      rd_data = 8'h00;
      for (int i = 0; i < MAX_LEN; i++) begin
         if (bus.rd_addr == 8'(i) && bus.rd_addr < frm_len_q) rd_data = held_q[i];
      end
   end

   assign bus.frm_valid = frm_valid;
   assign bus.frm_cmd   = frm_cmd_q;
   assign bus.frm_len   = frm_len_q;
   assign bus.rd_data   = rd_data;
   assign bus.frm_err   = frm_err_q;
   assign bus.err_code  = err_code_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// tb/tb_uart_frame_parser.sv - self-checking bench for uart_frame_parser
module tb_uart_frame_parser;
   localparam int MAX_LEN = 16;
   localparam int TMO     = 100;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   uart_frame_parser_if bus ();

   uart_frame_parser #(
      .HEADER(8'hA5),
      .MAX_LEN(MAX_LEN),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   int checks = 0;
   int errors = 0;
   int err_cnt = 0;
   logic [2:0] last_code = 3'd0;

   always @(negedge clk) begin
      if (rst_n && bus.frm_err) begin
         err_cnt   = err_cnt + 1;
         last_code = bus.err_code;
      end
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   typedef struct {
      string        name;
      int           nb;
      logic [191:0] bytes;
      logic         exp_valid;
      int           exp_errs;
      logic [2:0]   exp_code;
      logic [7:0]   exp_cmd;
      logic [7:0]   exp_len;
      logic [7:0]   exp_p0;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Called and returning on a falling edge; byte is consumed at the rising edge in between.
   task automatic send(input logic [7:0] b, input logic ack);
      bus.rx_data = b;
      bus.rx_done = 1'b1;
      bus.frm_ack = ack;
      @(negedge clk);
      bus.rx_done = 1'b0;
      bus.frm_ack = 1'b0;
   endtask

   task automatic rd(input logic [7:0] addr, output logic [7:0] data);
      bus.rd_addr = addr;
      #1;
      data = bus.rd_data;
      @(negedge clk);
   endtask

   task automatic ack_frame();
      bus.frm_ack = 1'b1;
      @(negedge clk);
      bus.frm_ack = 1'b0;
      check("valid_after_ack", bus.frm_valid, 1'b0);
   endtask

   function automatic vec_t mkv(input string name, input int nb, input logic [191:0] bytes,
                                input logic v, input int errs, input logic [2:0] code,
                                input logic [7:0] cmd, input logic [7:0] len, input logic [7:0] p0);
      vec_t r;
      r.name = name; r.nb = nb; r.bytes = bytes; r.exp_valid = v; r.exp_errs = errs;
      r.exp_code = code; r.exp_cmd = cmd; r.exp_len = len; r.exp_p0 = p0;
      return r;
   endfunction

   vec_t vec [8];
   logic [7:0] d;
   int e0;

   initial begin
      bus.rx_data = 8'h00;
      bus.rx_done = 1'b0;
      bus.rd_addr = 8'h00;
      bus.frm_ack = 1'b0;

      vec[0] = mkv("good3", 7, 192'({8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h13}),
                   1'b1, 0, 3'd0, 8'h10, 8'h03, 8'h11);
      vec[1] = mkv("zero_len", 4, 192'({8'hA5, 8'h7E, 8'h00, 8'h7E}),
                   1'b1, 0, 3'd0, 8'h7E, 8'h00, 8'h00);
      vec[2] = mkv("bad_chk", 4, 192'({8'hA5, 8'h7E, 8'h00, 8'h7F}),
                   1'b0, 1, 3'd1, 8'h00, 8'h00, 8'h00);
      vec[3] = mkv("oversize17", 3, 192'({8'hA5, 8'h01, 8'h11}),
                   1'b0, 1, 3'd2, 8'h00, 8'h00, 8'h00);
      vec[4] = mkv("after_over", 5, 192'({8'hA5, 8'h02, 8'h01, 8'h44, 8'h47}),
                   1'b1, 0, 3'd0, 8'h02, 8'h01, 8'h44);
      vec[5] = mkv("junk_first", 8, 192'({8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h01, 8'hAA, 8'hAA}),
                   1'b1, 0, 3'd0, 8'h01, 8'h01, 8'hAA);
      vec[6] = mkv("max_len", 20, 192'({8'hA5, 8'h30, 8'h10,
                   8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                   8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h10, 8'h30}),
                   1'b1, 0, 3'd0, 8'h30, 8'h10, 8'h01);
      vec[7] = mkv("len_ff", 3, 192'({8'hA5, 8'h31, 8'hFF}),
                   1'b0, 1, 3'd2, 8'h00, 8'h00, 8'h00);

      // Reset values while reset is asserted
      #1;
      check("rst_valid", bus.frm_valid, 1'b0);
      check("rst_cmd", bus.frm_cmd, 8'h00);
      check("rst_len", bus.frm_len, 8'h00);
      check("rst_err", bus.frm_err, 1'b0);
      check("rst_code", bus.err_code, 3'd0);
      check("rst_rd", bus.rd_data, 8'h00);
      idle(3);
      rst_n = 1'b1;
      idle(2);

      // Table of complete byte sequences
      for (int t = 0; t < 8; t++) begin
         e0 = err_cnt;
         for (int i = 0; i < vec[t].nb; i++) begin
            send(vec[t].bytes[8*(vec[t].nb-1-i) +: 8], 1'b0);
         end
         check({vec[t].name, "_valid"}, bus.frm_valid, vec[t].exp_valid);
         idle(2);
         check({vec[t].name, "_errs"}, err_cnt - e0, vec[t].exp_errs);
         if (vec[t].exp_errs != 0) check({vec[t].name, "_code"}, last_code, vec[t].exp_code);
         if (vec[t].exp_valid) begin
            check({vec[t].name, "_cmd"}, bus.frm_cmd, vec[t].exp_cmd);
            check({vec[t].name, "_len"}, bus.frm_len, vec[t].exp_len);
            rd(8'd0, d);
            check({vec[t].name, "_p0"}, d, vec[t].exp_p0);
            ack_frame();
         end
      end

      // Full readout, overrun while holding, then ack+HEADER priority
      send(8'hA5, 1'b0); send(8'h10, 1'b0); send(8'h03, 1'b0);
      send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h13, 1'b0);
      rd(8'd0, d); check("rd0", d, 8'h11);
      rd(8'd1, d); check("rd1", d, 8'h22);
      rd(8'd2, d); check("rd2", d, 8'h33);
      rd(8'd3, d); check("rd3_beyond", d, 8'h00);
      rd(8'd200, d); check("rd200_beyond", d, 8'h00);
      send(8'h55, 1'b0);
      check("ovr_pulse", bus.frm_err, 1'b1);
      check("ovr_code", bus.err_code, 3'd3);
      idle(1);
      check("ovr_pulse_end", bus.frm_err, 1'b0);
      check("ovr_still_valid", bus.frm_valid, 1'b1);
      check("ovr_cmd_kept", bus.frm_cmd, 8'h10);
      rd(8'd1, d); check("ovr_payload_kept", d, 8'h22);
      e0 = err_cnt;
      send(8'hA5, 1'b1);
      check("prio_valid_drop", bus.frm_valid, 1'b0);
      check("prio_no_err", bus.frm_err, 1'b0);
      send(8'h20, 1'b0); send(8'h00, 1'b0); send(8'h20, 1'b0);
      check("prio_valid", bus.frm_valid, 1'b1);
      check("prio_cmd", bus.frm_cmd, 8'h20);
      idle(2);
      check("prio_errs", err_cnt - e0, 0);
      check("code_holds", bus.err_code, 3'd3);

      // Reset while holding drops the frame
      rst_n = 1'b0;
      #1;
      check("rst_mid_valid", bus.frm_valid, 1'b0);
      check("rst_mid_code", bus.err_code, 3'd0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(1);

      // Ack outside HOLD is ignored
      send(8'hA5, 1'b0); send(8'h7E, 1'b0);
      ack_frame();
      send(8'h00, 1'b0); send(8'h7E, 1'b0);
      check("stray_ack_valid", bus.frm_valid, 1'b1);
      ack_frame();

      // Inter-byte timeout
      e0 = err_cnt;
      send(8'hA5, 1'b0); send(8'h01, 1'b0);
      idle(TMO - 1);
      check("tmo_quiet_99", bus.frm_err, 1'b0);
      idle(1);
`ifdef FRAME_TIMEOUT_EN
      check("tmo_pulse", bus.frm_err, 1'b1);
      check("tmo_code", bus.err_code, 3'd4);
      send(8'hA5, 1'b0); send(8'h05, 1'b0); send(8'h00, 1'b0); send(8'h05, 1'b0);
      check("tmo_next_valid", bus.frm_valid, 1'b1);
      check("tmo_next_cmd", bus.frm_cmd, 8'h05);
`else
      check("no_tmo_pulse", bus.frm_err, 1'b0);
      send(8'h00, 1'b0); send(8'h01, 1'b0);
      check("no_tmo_valid", bus.frm_valid, 1'b1);
      check("no_tmo_cmd", bus.frm_cmd, 8'h01);
`endif
      idle(2);
      check("tmo_errs", err_cnt - e0, `ifdef FRAME_TIMEOUT_EN 1 `else 0 `endif);
      ack_frame();

      // Randomized frames against a frame-level reference model
      for (int f = 0; f < 150; f++) begin
         automatic int nj = $urandom_range(0, 2);
         automatic int kind = $urandom_range(0, 9);
         automatic logic [7:0] cmd = 8'($urandom);
         automatic logic [7:0] len;
         automatic logic [7:0] exp_chk;
         automatic logic [7:0] pl [$];
         automatic logic [7:0] b;
         for (int j = 0; j < nj; j++) begin
            b = 8'($urandom);
            if (b == 8'hA5) b = 8'h00;
            send(b, 1'b0);
            check("rnd_junk_quiet", bus.frm_err, 1'b0);
         end
         len = (kind == 0) ? 8'($urandom_range(MAX_LEN + 1, 255)) : 8'($urandom_range(0, MAX_LEN));
         send(8'hA5, 1'b0); idle($urandom_range(0, 2));
         send(cmd, 1'b0);   idle($urandom_range(0, 2));
         send(len, 1'b0);
         if (kind == 0) begin
            check("rnd_over_err", bus.frm_err, 1'b1);
            check("rnd_over_code", bus.err_code, 3'd2);
            continue;
         end
         exp_chk = cmd ^ len;
         for (int k = 0; k < len; k++) begin
            pl.push_back(8'($urandom));
            exp_chk = exp_chk ^ pl[k];
         end
         foreach (pl[k]) begin
            idle($urandom_range(0, 2));
            send(pl[k], 1'b0);
         end
         idle($urandom_range(0, 2));
         if (kind <= 2) begin
            send(exp_chk ^ 8'($urandom_range(1, 255)), 1'b0);
            check("rnd_bad_err", bus.frm_err, 1'b1);
            check("rnd_bad_code", bus.err_code, 3'd1);
            check("rnd_bad_valid", bus.frm_valid, 1'b0);
            continue;
         end
         send(exp_chk, 1'b0);
         check("rnd_valid", bus.frm_valid, 1'b1);
         check("rnd_err", bus.frm_err, 1'b0);
         check("rnd_cmd", bus.frm_cmd, cmd);
         check("rnd_len", bus.frm_len, len);
         foreach (pl[k]) begin
            rd(8'(k), d);
            check("rnd_payload", d, pl[k]);
         end
         rd(len, d);
         check("rnd_rd_beyond", d, 8'h00);
         if (kind == 3) begin
            send(8'($urandom), 1'b0);
            check("rnd_ovr_err", bus.frm_err, 1'b1);
            check("rnd_ovr_code", bus.err_code, 3'd3);
            check("rnd_ovr_valid", bus.frm_valid, 1'b1);
         end
         if (kind >= 8) begin
            b = 8'($urandom);
            if (b == 8'hA5) b = 8'h3C;
            send(b, 1'b1);
            check("rnd_ackbyte_valid", bus.frm_valid, 1'b0);
            check("rnd_ackbyte_err", bus.frm_err, 1'b0);
         end else begin
            ack_frame();
         end
      end

      idle(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
